// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep controller.
// The FSM encoding and vector-index sizing are used by the top level.
package tt_sweep_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

  localparam int NUM_VEC = 4;
  localparam int IDX_W   = 2;

endpackage

// File: rtl/settle_timer.sv
// Settle-time down-counter. A load makes expire assert SETTLE_CYC enabled
// edges later, so that edge is the sample edge for the current drive.
module settle_timer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 4'(SETTLE_CYC - 1);
    end else if (en && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == 4'd0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Steps a two-input datapath through {x,y} = 00,01,10,11, samples its output
// after a settle time into a truth table, and compares it against an expected table.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic [3:0]       exp_tt,
  input  logic             dut_z,
  output logic             drv_x,
  output logic             drv_y,
  output logic             busy,
  output logic             done,
  output logic [3:0]       tt,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         tt_q, tt_d;
  logic [3:0]         exp_q, exp_d;
  logic               done_q, done_d;
  logic               mismatch_q, mismatch_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic accept, expire, sample, last;

  assign accept = (state_q == IDLE) && start;
  // Abort takes priority over a coinciding sample edge: nothing is captured.
  assign sample = (state_q == SETTLE) && expire && !abort;
  assign last   = sample && (idx_q == IDX_W'(NUM_VEC - 1));

  settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept || sample),
    .en     (state_q == SETTLE),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (abort || (last && !cont)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The index wraps 3 -> 0 on the last sample, which also returns the drive to 00.
  always_comb begin
    busy  = (state_q == SETTLE);
    drv_x = idx_q[1];
    drv_y = idx_q[0];
  end

  always_comb begin
    idx_d      = idx_q;
    tt_d       = tt_q;
    exp_d      = exp_q;
    done_d     = 1'b0;
    mismatch_d = mismatch_q;
    err_d      = err_q;
    if (accept) begin
      idx_d = '0;
      exp_d = exp_tt;
    end else if ((state_q == SETTLE) && abort) begin
      idx_d = '0;
    end else if (sample) begin
      idx_d       = idx_q + IDX_W'(1);
      tt_d[idx_q] = dut_z;
    end
    if (last) begin
      done_d     = 1'b1;
      mismatch_d = ({dut_z, tt_q[2:0]} != exp_q);
      if (mismatch_d && (err_q != {ERR_W{1'b1}})) begin
        err_d = err_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      tt_q       <= '0;
      exp_q      <= '0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      idx_q      <= idx_d;
      tt_q       <= tt_d;
      exp_q      <= exp_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  assign done     = done_q;
  assign tt       = tt_q;
  assign mismatch = mismatch_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: XOR or stuck-at-1 datapath model, scoreboard of
// expected {tt, mismatch, err_cnt} popped on every done pulse.
module tb_tt_sweep_ctrl;

  localparam int SETTLE = 2;
  localparam int ERR_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             cont;
  logic [3:0]       exp_tt;
  logic             dut_z;
  logic             drv_x;
  logic             drv_y;
  logic             busy;
  logic             done;
  logic [3:0]       tt;
  logic             mismatch;
  logic [ERR_W-1:0] err_cnt;

  logic stuck;
  assign dut_z = stuck ? 1'b1 : (drv_x ^ drv_y);

  always #5 clk = ~clk;

  tt_sweep_ctrl #(.SETTLE_CYC(SETTLE), .ERR_W(ERR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .cont     (cont),
    .exp_tt   (exp_tt),
    .dut_z    (dut_z),
    .drv_x    (drv_x),
    .drv_y    (drv_y),
    .busy     (busy),
    .done     (done),
    .tt       (tt),
    .mismatch (mismatch),
    .err_cnt  (err_cnt)
  );

  typedef struct packed {
    logic [3:0]       tt;
    logic             mis;
    logic [ERR_W-1:0] err;
  } res_t;

  res_t sb_q[$];
  res_t mon_r;
  int   checks    = 0;
  int   errors    = 0;
  int   done_seen = 0;

  logic [3:0] m_tt;
  logic       m_mis;
  int         m_err;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_seen++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: tt=%b mismatch=%b err_cnt=%0d, no sweep expected", tt, mismatch, err_cnt);
      end else begin
        mon_r = sb_q.pop_front();
        if ({tt, mismatch, err_cnt} !== mon_r) begin
          errors++;
          $display("FAIL sweep_result: got tt=%b mis=%b err=%0d, want tt=%b mis=%b err=%0d",
                   tt, mismatch, err_cnt, mon_r.tt, mon_r.mis, mon_r.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input logic [3:0] sweep_tt, input logic [3:0] e);
    m_tt  = sweep_tt;
    m_mis = (sweep_tt != e);
    if (m_mis && m_err < 255) m_err++;
    sb_q.push_back({sweep_tt, m_mis, 8'(m_err)});
  endtask

  task automatic do_start(input logic [3:0] e);
    exp_tt = e;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({drv_x, drv_y, busy, done, tt, mismatch, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want all zero", {drv_x, drv_y, busy, done, tt, mismatch, err_cnt});
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();
    stuck = 1'b1;
    do_start(4'b0110);
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if ({drv_x, drv_y} !== 2'b10) begin
      errors++;
      $display("FAIL reset_pre_drive: got %b, want 10", {drv_x, drv_y});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({drv_x, drv_y, busy, done, tt, mismatch, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_async_mid_sweep: got %b, want all zero", {drv_x, drv_y, busy, done, tt, mismatch, err_cnt});
    end
    tick();
    tick();
    rst_n = 1'b1;
    m_tt = 4'b0000; m_mis = 1'b0; m_err = 0;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if ({busy, drv_x, drv_y, done_seen} !== {3'b000, 32'd0}) begin
      errors++;
      $display("FAIL reset_idle_after: busy=%b drv=%b%b dones=%0d, want 0 00 0", busy, drv_x, drv_y, done_seen);
    end
  endtask

  task automatic test_correct();
    logic [1:0] want_drv;
    stuck = 1'b0;
    cont  = 1'b0;
    push_sweep(4'b0110, 4'b0110);
    do_start(4'b0110);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      want_drv = (k == 8) ? 2'b00 : 2'(k / 2);
      checks++;
      if ({drv_x, drv_y, busy, done} !== {want_drv, (k != 8), (k == 8)}) begin
        errors++;
        $display("FAIL correct_seq k=%0d: drv=%b%b busy=%b done=%b, want drv=%b busy=%b done=%b",
                 k, drv_x, drv_y, busy, done, want_drv, (k != 8), (k == 8));
      end
    end
    checks++;
    if ({tt, mismatch, err_cnt} !== {4'b0110, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL correct_result: tt=%b mis=%b err=%0d, want 0110 0 0", tt, mismatch, err_cnt);
    end
    tick();
  endtask

  task automatic test_faulty();
    bit got;
    stuck = 1'b1;
    for (int s = 1; s <= 2; s++) begin
      push_sweep(4'b1111, 4'b0110);
      do_start(4'b0110);
      wait_done(12, got);
      checks++;
      if (!got || {tt, mismatch, err_cnt} !== {4'b1111, 1'b1, 8'(s)}) begin
        errors++;
        $display("FAIL faulty_sweep%0d: done=%b tt=%b mis=%b err=%0d, want done tt=1111 mis=1 err=%0d",
                 s, got, tt, mismatch, err_cnt, s);
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    bit got;
    stuck = 1'b1;
    for (int n = 0; n < 254; n++) push_sweep(4'b1111, 4'b0110);
    cont = 1'b1;
    do_start(4'b0110);
    for (int n = 0; n < 254; n++) begin
      wait_done(12, got);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL saturate_timeout: sweep %0d produced no done", n);
        break;
      end
      if (n == 252) cont = 1'b0;
    end
    tick();
    checks++;
    if ({busy, err_cnt} !== {1'b0, 8'd255}) begin
      errors++;
      $display("FAIL saturate_hold: busy=%b err=%0d, want 0 255", busy, err_cnt);
    end
  endtask

  task automatic test_cont();
    logic [1:0] want_drv;
    stuck = 1'b0;
    for (int n = 0; n < 4; n++) push_sweep(4'b0110, 4'b0110);
    cont = 1'b1;
    do_start(4'b0110);
    for (int k = 1; k <= 32; k++) begin
      tick();
      want_drv = 2'((k % 8) / 2);
      checks++;
      if ({drv_x, drv_y, busy, done} !== {want_drv, (k != 32), (k % 8 == 0)}) begin
        errors++;
        $display("FAIL cont_seq k=%0d: drv=%b%b busy=%b done=%b, want drv=%b busy=%b done=%b",
                 k, drv_x, drv_y, busy, done, want_drv, (k != 32), (k % 8 == 0));
      end
      if (k == 24) cont = 1'b0;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit got;
    int n0;
    stuck = 1'b0;
    n0 = done_seen;
    push_sweep(4'b0110, 4'b0110);
    do_start(4'b0110);
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(12, got);
    for (int k = 0; k < 12; k++) tick();
    checks++;
    if (!got || done_seen !== n0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_while_busy: done=%b dones=%0d busy=%b, want done dones=%0d busy=0",
               got, done_seen - n0, busy, 1);
    end
  endtask

  task automatic test_abort();
    int n0;
    stuck = 1'b1;
    n0 = done_seen;
    do_start(4'b0110);
    for (int k = 0; k < 5; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, drv_x, drv_y} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle: busy=%b drv=%b%b, want 0 00", busy, drv_x, drv_y);
    end
    for (int k = 0; k < 10; k++) tick();
    m_tt = {m_tt[3:2], 2'b11};
    checks++;
    if ({tt, mismatch, err_cnt} !== {m_tt, m_mis, 8'(m_err)} || done_seen !== n0) begin
      errors++;
      $display("FAIL abort_state: tt=%b mis=%b err=%0d dones=%0d, want tt=%b mis=%b err=%0d dones=0",
               tt, mismatch, err_cnt, done_seen - n0, m_tt, m_mis, m_err);
    end
  endtask

  task automatic test_abort_last();
    int n0;
    stuck = 1'b1;
    n0 = done_seen;
    do_start(4'b0110);
    for (int k = 0; k < 7; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL abort_last_edge: busy=%b done=%b, want 0 0", busy, done);
    end
    for (int k = 0; k < 6; k++) tick();
    m_tt = {m_tt[3], 3'b111};
    checks++;
    if ({tt, mismatch, err_cnt} !== {m_tt, m_mis, 8'(m_err)} || done_seen !== n0) begin
      errors++;
      $display("FAIL abort_last_state: tt=%b mis=%b err=%0d dones=%0d, want tt=%b mis=%b err=%0d dones=0",
               tt, mismatch, err_cnt, done_seen - n0, m_tt, m_mis, m_err);
    end
  endtask

  initial begin
    start  = 1'b0;
    abort  = 1'b0;
    cont   = 1'b0;
    exp_tt = 4'b0000;
    stuck  = 1'b0;
    m_tt   = 4'b0000;
    m_mis  = 1'b0;
    m_err  = 0;
    test_reset();
    test_correct();
    test_faulty();
    test_saturate();
    test_cont();
    test_back_to_back();
    test_abort();
    test_abort_last();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL missing_done: %0d expected sweeps never completed, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
